// File: rtl/hmac_sha_sequencer.sv
// HMAC-SHA256 control sequencer for a single byte-stream SHA-256 core.
// Buffers (or pre-hashes) the key, then runs the inner pass
// (K^ipad || message) and the outer pass (K^opad || inner digest).
module hmac_sha_sequencer #(
  parameter int         BLOCK_BYTES = 64,
  parameter logic [7:0] IPAD        = 8'h36,
  parameter logic [7:0] OPAD        = 8'h5c
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [7:0]   key_data,
  input  logic         key_last,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [7:0]   msg_data,
  input  logic         msg_last,
  output logic         busy,
  output logic         done,
  output logic [255:0] mac,
  output logic         sha_rst_n,
  output logic         sha_byte_rdy,
  output logic [7:0]   sha_data,
  output logic         sha_byte_stop,
  input  logic         sha_block_full,
  input  logic [255:0] sha_hash,
  input  logic         sha_done_hash
);

  localparam int         AW  = $clog2(BLOCK_BYTES);
  localparam logic [6:0] BLK = 7'(BLOCK_BYTES);

  typedef enum logic [3:0] {
    S_IDLE, S_KEY_LOAD, S_KEY_SPILL, S_KEY_FWD, S_KEY_FIN,
    S_CLR_I, S_IPAD, S_MSG, S_FIN_I,
    S_CLR_O, S_OPAD, S_DIG, S_FIN_O
  } state_t;

  state_t         state_reg, state_next;
  logic [6:0]     idx_reg;        // byte index inside the current feed state
  logic [6:0]     cnt_reg;        // key bytes buffered, saturates at BLK
  logic [7:0]     skid_reg;       // first key byte beyond one block
  logic           skid_last_reg;
  logic [7:0]     kbuf_reg [BLOCK_BYTES];
  logic [7:0]     inner_reg [32];
  logic [255:0]   mac_reg;
  logic           done_reg;
  logic [31:0][7:0] hash_bytes;   // hash_bytes[31] is the most significant byte

  logic sha_clr, take, idx_step, start_ok;
  logic key_wr, key_spill_in, hash_load, inner_load, mac_load;

  assign hash_bytes   = sha_hash;
  assign start_ok     = (state_reg == S_IDLE) && start && !done_reg;
  assign key_wr       = (state_reg == S_KEY_LOAD) && key_valid && (cnt_reg < BLK);
  assign key_spill_in = (state_reg == S_KEY_LOAD) && key_valid && (cnt_reg == BLK);
  assign hash_load    = (state_reg == S_KEY_FIN) && sha_done_hash;
  assign inner_load   = (state_reg == S_FIN_I) && sha_done_hash;
  assign mac_load     = (state_reg == S_FIN_O) && sha_done_hash;
  assign take         = sha_byte_rdy && !sha_block_full;
  // The first KEY_SPILL cycle is the core clear, so it advances the index too.
  assign idx_step     = (take && (state_reg inside {S_KEY_SPILL, S_IPAD, S_OPAD, S_DIG})) ||
                        ((state_reg == S_KEY_SPILL) && (idx_reg == 7'd0));

  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign mac       = mac_reg;
  assign sha_rst_n = !(reset || sha_clr);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode and everything presented to the core and the byte sources.
  always_comb begin
    state_next    = state_reg;
    key_ready     = 1'b0;
    msg_ready     = 1'b0;
    sha_byte_rdy  = 1'b0;
    sha_data      = 8'h00;
    sha_byte_stop = 1'b0;
    sha_clr       = 1'b0;
    case (state_reg)
      S_IDLE: if (start_ok) state_next = S_KEY_LOAD;
      S_KEY_LOAD: begin
        key_ready = 1'b1;
        if (key_valid) begin
          if (cnt_reg == BLK) state_next = S_KEY_SPILL;
          else if (key_last)  state_next = S_CLR_I;
        end
      end
      S_KEY_SPILL: begin
        if (idx_reg == 7'd0) begin
          sha_clr = 1'b1;
        end else begin
          sha_byte_rdy = 1'b1;
          sha_data     = (idx_reg <= BLK) ? kbuf_reg[AW'(idx_reg - 7'd1)] : skid_reg;
          if (!sha_block_full && (idx_reg == BLK + 7'd1))
            state_next = skid_last_reg ? S_KEY_FIN : S_KEY_FWD;
        end
      end
      S_KEY_FWD: begin
        key_ready    = !sha_block_full;
        sha_byte_rdy = key_valid;
        sha_data     = key_data;
        if (key_valid && !sha_block_full && key_last) state_next = S_KEY_FIN;
      end
      S_KEY_FIN: begin
        sha_byte_stop = 1'b1;
        if (sha_done_hash) state_next = S_CLR_I;
      end
      S_CLR_I: begin
        sha_clr    = 1'b1;
        state_next = S_IPAD;
      end
      S_IPAD: begin
        sha_byte_rdy = 1'b1;
        sha_data     = kbuf_reg[idx_reg[AW-1:0]] ^ IPAD;
        if (!sha_block_full && (idx_reg == BLK - 7'd1)) state_next = S_MSG;
      end
      S_MSG: begin
        msg_ready    = !sha_block_full;
        sha_byte_rdy = msg_valid;
        sha_data     = msg_data;
        if (msg_valid && !sha_block_full && msg_last) state_next = S_FIN_I;
      end
      S_FIN_I: begin
        sha_byte_stop = 1'b1;
        if (sha_done_hash) state_next = S_CLR_O;
      end
      S_CLR_O: begin
        sha_clr    = 1'b1;
        state_next = S_OPAD;
      end
      S_OPAD: begin
        sha_byte_rdy = 1'b1;
        sha_data     = kbuf_reg[idx_reg[AW-1:0]] ^ OPAD;
        if (!sha_block_full && (idx_reg == BLK - 7'd1)) state_next = S_DIG;
      end
      S_DIG: begin
        sha_byte_rdy = 1'b1;
        sha_data     = inner_reg[idx_reg[4:0]];
        if (!sha_block_full && (idx_reg == 7'd31)) state_next = S_FIN_O;
      end
      S_FIN_O: begin
        sha_byte_stop = 1'b1;
        if (sha_done_hash) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Counters, skid byte and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg       <= 7'd0;
      cnt_reg       <= 7'd0;
      skid_reg      <= 8'h00;
      skid_last_reg <= 1'b0;
      mac_reg       <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= mac_load;
      if (mac_load) mac_reg <= sha_hash;
      if (state_next != state_reg) idx_reg <= 7'd0;
      else if (idx_step)           idx_reg <= idx_reg + 7'd1;
      if (start_ok)    cnt_reg <= 7'd0;
      else if (key_wr) cnt_reg <= cnt_reg + 7'd1;
      if (key_spill_in) begin
        skid_reg      <= key_data;
        skid_last_reg <= key_last;
      end
    end
  end

  // Key block: zeroed per MAC, filled MSB-first, or replaced by the key digest.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (reset || start_ok) begin
        kbuf_reg[i] <= 8'h00;
      end else if (hash_load) begin
        kbuf_reg[i] <= 8'h00;
        if (i < 32) kbuf_reg[i] <= hash_bytes[5'(31 - i)];
      end else if (key_wr && (cnt_reg == 7'(i))) begin
        kbuf_reg[i] <= key_data;
      end
    end
  end

  // Inner digest, stored byte 0 = most significant.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (inner_load) inner_reg[i] <= hash_bytes[5'(31 - i)];
    end
  end

endmodule

// File: doc/hmac_sha_sequencer.md
# hmac_sha_sequencer

Control FSM that sequences one byte-stream `top_sha` SHA-256 core through a complete HMAC-SHA256 computation. It accepts a key stream and a message stream, and hashes keys longer than 64 bytes first. It then drives the inner pass (K⊕ipad ‖ message) and the outer pass (K⊕opad ‖ inner digest), and presents the 256-bit MAC. It sits between the UART/byte front end and the SHA core, replacing ad-hoc per-stage glue.

## Interface
Parameters:
- `BLOCK_BYTES`, 64: SHA block size in bytes; fixes the key buffer at 512 bits.
- `IPAD`, 8'h36: inner pad byte.
- `OPAD`, 8'h5c: outer pad byte.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a new MAC; ignored while `busy`
- `key_valid` / `key_ready`  in/out  1  key byte handshake
- `key_data`  in  8  key byte, MSB-first order
- `key_last`  in  1  marks the final key byte
- `msg_valid` / `msg_ready`  in/out  1  message byte handshake
- `msg_data`  in  8  message byte
- `msg_last`  in  1  marks the final message byte
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse when `mac` becomes valid
- `mac`  out  256  HMAC result, held until the next accepted `start`
- `sha_rst_n`  out  1  core clear, active-low
- `sha_byte_rdy`  out  1  `sha_data` is valid
- `sha_data`  out  8  byte to the core
- `sha_byte_stop`  out  1  end of message; the core pads and finalises
- `sha_block_full`  in  1  core not accepting bytes
- `sha_hash`  in  256  core digest
- `sha_done_hash`  in  1  level; digest valid until the core is cleared

## Operation
- Core contract: a byte is consumed on a cycle where `sha_byte_rdy`=1 and `sha_block_full`=0. The sequencer holds `sha_data` until the byte is consumed. `sha_byte_stop` stays high until `sha_done_hash`=1.
- Key and message are each at least 1 byte. Zero-length key or message is not supported.
- `key_ready`=1 only in KEY_LOAD and KEY_FWD. `msg_ready`=1 only in MSG, and only when `sha_block_full`=0.
- States:
  - IDLE: on `start`, clear the key buffer and count, then go to KEY_LOAD.
  - KEY_LOAD: each accepted byte is written to `kbuf[511-8*cnt -: 8]` and `cnt` increments.
    - If the byte is `key_last` and total ≤64, go to CLR_I.
    - If a 65th byte arrives, go to KEY_SPILL; that byte is held in the skid register and `key_ready` drops.
  - KEY_SPILL: feed all 64 buffered bytes, then the skid byte, to the core. Go to KEY_FWD.
    - The core is cleared on entry: `sha_rst_n`=0 for 1 cycle.
  - KEY_FWD: forward key bytes straight to the core. After `key_last` is consumed, go to KEY_FIN.
  - KEY_FIN: assert stop. On `sha_done_hash`, set `kbuf` = {`sha_hash`, 256'b0}, then go to CLR_I.
  - CLR_I: `sha_rst_n`=0 for 1 cycle, then go to IPAD.
  - IPAD: feed `kbuf` byte i ⊕ `IPAD` for i = 0..63, then go to MSG.
  - MSG: pass `msg_data` through as `sha_data`. After `msg_last` is consumed, go to FIN_I.
  - FIN_I: assert stop. On `sha_done_hash`, latch `inner` ← `sha_hash`, then go to CLR_O.
  - CLR_O: same as CLR_I, then go to OPAD.
  - OPAD: same as IPAD with `OPAD`, then go to DIG.
  - DIG: feed `inner` bytes, MSB first, 32 bytes, then go to FIN_O.
  - FIN_O: assert stop. On `sha_done_hash`, set `mac` ← `sha_hash` and pulse `done`, then go to IDLE.
- Counters:
  - Byte index: 7 bits.
  - Key count: saturating 7 bits, only compared against 64.

## Timing
- Reset values:
  - `busy`, `done`, `key_ready`, `msg_ready`, `sha_byte_rdy`, `sha_byte_stop` = 0.
  - `sha_rst_n` = 0 while `reset` is high.
  - `mac` and `sha_data` = 0.
  - State = IDLE.
- Reset asserted mid-operation aborts immediately, with no `done`. `sha_rst_n` is driven low and the core is re-cleared.
- `busy` rises the cycle after `start`. `start` is ignored when `busy`=1 or `done`=1.
- Latency with `sha_block_full` never asserted and a short key (≤64 bytes): from the `msg_last` handshake to `done`, the cost is
  - core finalise time for the inner pass,
  - plus 1 cycle for CLR_O,
  - plus 64 + 32 feed cycles,
  - plus core finalise time for the outer pass,
  - plus 1 cycle.
- `sha_block_full`=1 stalls every feed state with no byte lost or duplicated.
- `msg_valid` may drop mid-stream: `sha_byte_rdy` follows `msg_valid` in MSG.
- `sha_done_hash` is only honoured in the FIN/KEY_FIN states. A stale level elsewhere is ignored.

## Test plan
- RFC 4231 TC1: key = 20×0x0b, msg = "Hi There" → `mac` = b0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7, `done` pulses for 1 cycle.
- RFC 4231 TC2: key "Jefe", msg "what do ya want for nothing?", with `msg_valid` randomly gapped → `mac` = 5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843.
- RFC 4231 TC6: key = 131×0xaa (forces KEY_SPILL/KEY_FWD), msg "Test Using Larger Than Block-Size Key - Hash Key First" → `mac` = 60e431591ee0b67f0d8a26aacbf5b77f8e0bc6213728c5140546040f0ee37f54.
- Key of exactly 64 bytes → no key hash. Check that `sha_rst_n` pulses exactly twice and that IPAD feeds 64 bytes.
- Randomly assert `sha_block_full` during TC2 → same MAC. Scoreboard checks that the core receives exactly 64+28 bytes on the inner pass and 64+32 on the outer pass.
- `start` pulsed while `busy` → ignored and the result is unchanged. `reset` asserted during MSG → outputs return to their reset values next cycle, no `done`. A following TC1 run is correct.
